// File: rtl/mm_tile_ctrl.sv
// ---------------------------------------------------------------------------
// mm_tile_ctrl -- tiled matrix-multiply sequencer for C[512x512] = A x B.
//
// Walks all 1024 16x16 output tiles (row group outer, column group inner),
// driving read addresses into 16 banked A buffers and a 16-lane B buffer,
// and pulses completion per tile and per matrix.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_mode   [1:0] 0=INT8, 1=INT4, 2=INT4_VSQ, 3=reserved (sampled with i_start)
//   i_start        one-cycle start request
//   o_tile_done    one-cycle pulse per completed output tile
//   o_mtrx_done    one-cycle pulse when the whole matrix is done
//   o_busy_cycles  [31:0] read cycles of the last run (only with MM_CTRL_PERF_EN)
//
// Optional build macro: MM_CTRL_PERF_EN adds the o_busy_cycles counter.
//
// Buffers hold no reset; they are preloaded through the backdoor
// (A_BUF[b].ram_a.mem, ram_b.mem) before i_start.
// ---------------------------------------------------------------------------

// Synchronous-read buffer, 1-cycle latency, NPORT independent read ports.
module mm_tile_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 264,
    parameter int NPORT = 1
) (
    input  logic                i_clk,
    input  logic                i_rd_en,
    input  logic [NPORT*AW-1:0] i_rd_addr,
    output logic [NPORT*DW-1:0] o_rd_data,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [DW-1:0]       i_wr_data
);
    logic [DW-1:0] mem [0:DEPTH-1];

    // Loader hook; the controller ties it off and content comes in by backdoor.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : RD_PORT
            logic [DW-1:0] rd_data_q;
            always_ff @(posedge i_clk) begin
                if (i_rd_en) begin
                    rd_data_q <= mem[i_rd_addr[gi*AW +: AW]];
                end
            end
            assign o_rd_data[gi*DW +: DW] = rd_data_q;
        end
    endgenerate
endmodule

module mm_tile_ctrl #(
    parameter int N_BANK  = 16,
    parameter int M_DIM   = 512,
    parameter int N_DIM   = 512,
    parameter int K_DIM   = 256,
    parameter int VEC_LEN = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_mode,
    input  logic        i_start,
    output logic        o_tile_done,
    output logic        o_mtrx_done
`ifdef MM_CTRL_PERF_EN
    ,
    output logic [31:0] o_busy_cycles
`endif
);
    localparam int DW      = 4*VEC_LEN + 8;       // 64 nibbles + scale byte
    localparam int N_VEC   = K_DIM / VEC_LEN;     // 4 vectors per row/column
    localparam int A_DEPTH = (M_DIM / N_BANK) * N_VEC;
    localparam int B_DEPTH = N_DIM * N_VEC;
    localparam int A_AW    = 7;
    localparam int B_AW    = 11;
    localparam logic [4:0] RG_LAST = 5'(M_DIM / N_BANK - 1);
    localparam logic [4:0] CG_LAST = 5'(N_DIM / N_BANK - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [2:0] cyc_q, cyc_d;       // cycle within the current tile
    logic [4:0] cg_q, cg_d;
    logic [4:0] rg_q, rg_d;
    logic       last_rd_q, last_rd_d;   // final read of a tile was just issued
    logic       mlast_q, mlast_d;       // final read of the matrix was just issued
    logic       tile_done_q, tile_done_d;
    logic       mtrx_done_q, mtrx_done_d;
    logic       rd_en;
    logic [1:0] vec;
    logic [2:0] cyc_max;
    logic       start_acc;

    assign start_acc = (state_q == ST_IDLE) && i_start && (i_mode != 2'd3);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cyc_d       = cyc_q;
        cg_d        = cg_q;
        rg_d        = rg_q;
        last_rd_d   = 1'b0;
        mlast_d     = 1'b0;
        tile_done_d = last_rd_q;   // pulse lines up with the last read's data
        mtrx_done_d = 1'b0;
        rd_en       = 1'b0;

        case (mode_q)
            2'd0:    cyc_max = 3'd7;
            2'd2:    cyc_max = 3'd4;
            default: cyc_max = 3'd3;
        endcase

        // INT8 holds each vector for two nibble-plane passes; VSQ re-reads
        // vec 3 in the fifth cycle to fetch its scale byte.
        case (mode_q)
            2'd0:    vec = cyc_q[2:1];
            2'd2:    vec = (cyc_q == 3'd4) ? 2'd3 : cyc_q[1:0];
            default: vec = cyc_q[1:0];
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    mode_d  = i_mode;
                    state_d = ST_RUN;
                    cyc_d   = 3'd0;
                    cg_d    = 5'd0;
                    rg_d    = 5'd0;
                end
            end
            ST_RUN: begin
                if (mlast_q) begin
                    // One drain cycle lets the final tile pulse go out first.
                    state_d = ST_DONE;
                end else begin
                    rd_en = 1'b1;
                    if (cyc_q == cyc_max) begin
                        cyc_d     = 3'd0;
                        last_rd_d = 1'b1;
                        cg_d      = cg_q + 5'd1;
                        if (cg_q == CG_LAST) begin
                            rg_d = rg_q + 5'd1;
                            if (rg_q == RG_LAST) begin
                                mlast_d = 1'b1;
                            end
                        end
                    end else begin
                        cyc_d = cyc_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                mtrx_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 2'd1;
            cyc_q       <= 3'd0;
            cg_q        <= 5'd0;
            rg_q        <= 5'd0;
            last_rd_q   <= 1'b0;
            mlast_q     <= 1'b0;
            tile_done_q <= 1'b0;
            mtrx_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cyc_q       <= cyc_d;
            cg_q        <= cg_d;
            rg_q        <= rg_d;
            last_rd_q   <= last_rd_d;
            mlast_q     <= mlast_d;
            tile_done_q <= tile_done_d;
            mtrx_done_q <= mtrx_done_d;
        end
    end

    assign o_tile_done = tile_done_q;
    assign o_mtrx_done = mtrx_done_q;

    // A banks: every bank reads word rg*4+vec (row b+16*rg of A).
    logic [DW-1:0] unused_a_rd [N_BANK];
    genvar gi;
    generate
        for (gi = 0; gi < N_BANK; gi++) begin : A_BUF
            mm_tile_ram #(.DEPTH(A_DEPTH), .AW(A_AW), .DW(DW), .NPORT(1)) ram_a (
                .i_clk     (i_clk),
                .i_rd_en   (rd_en),
                .i_rd_addr ({rg_q, vec}),
                .o_rd_data (unused_a_rd[gi]),
                .i_wr_en   (1'b0),
                .i_wr_addr ('0),
                .i_wr_data ('0)
            );
        end
    endgenerate

    // B: lane j reads column cg*16+j, i.e. word {cg, j, vec}.
    logic [N_BANK*B_AW-1:0] b_addr;
    logic [N_BANK*DW-1:0]   unused_b_rd;
    generate
        for (gi = 0; gi < N_BANK; gi++) begin : B_LANE
            localparam logic [3:0] LANE = 4'(gi);
            assign b_addr[gi*B_AW +: B_AW] = {cg_q, LANE, vec};
        end
    endgenerate

    mm_tile_ram #(.DEPTH(B_DEPTH), .AW(B_AW), .DW(DW), .NPORT(N_BANK)) ram_b (
        .i_clk     (i_clk),
        .i_rd_en   (rd_en),
        .i_rd_addr (b_addr),
        .o_rd_data (unused_b_rd),
        .i_wr_en   (1'b0),
        .i_wr_addr ('0),
        .i_wr_data ('0)
    );

`ifdef MM_CTRL_PERF_EN
    logic [31:0] busy_q, busy_d;
    always_comb begin
        busy_d = busy_q;
        if (start_acc) begin
            busy_d = 32'd0;
        end else if (rd_en) begin
            busy_d = busy_q + 32'd1;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end
    assign o_busy_cycles = busy_q;
`else
    // No cycle counter in this build.
`endif
endmodule

// File: tb/tb_mm_tile_ctrl.sv
// Scoreboard bench for mm_tile_ctrl: stimulus pushes expected pulse edges and
// buffer read-data samples into queues; a monitor on the falling edge pops and
// compares whenever an output is asserted or an expected event is due.
module tb_mm_tile_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] i_mode;
    logic       i_start;
    logic       o_tile_done;
    logic       o_mtrx_done;
`ifdef MM_CTRL_PERF_EN
    logic [31:0] busy;
`endif

    mm_tile_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mode      (i_mode),
        .i_start     (i_start),
        .o_tile_done (o_tile_done),
        .o_mtrx_done (o_mtrx_done)
`ifdef MM_CTRL_PERF_EN
        ,
        .o_busy_cycles (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           e;
        logic [263:0] val;
        logic [263:0] mask;
    } dchk_t;

    int    tq[$];
    int    mq[$];
    dchk_t dq[$];
    int    edge_cnt = 0;
    int    e0;
    int    checks = 0;
    int    failures = 0;
    int    tile_seen = 0;
    int    mtrx_seen = 0;

    localparam logic [263:0] FULL  = {264{1'b1}};
    localparam logic [263:0] SCALE = 264'hFF;

    function automatic logic [263:0] mkword(input logic [7:0] fill, input logic [7:0] scale);
        return {{32{fill}}, scale};
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor
    always @(negedge clk) begin
        logic [263:0] got;
        dchk_t        ent;
        if (o_tile_done) tile_seen++;
        if (o_mtrx_done) mtrx_seen++;
        if (tq.size() > 0 && tq[0] == edge_cnt) begin
            checks++;
            void'(tq.pop_front());
            if (!o_tile_done) begin
                failures++;
                $display("FAIL tile_done missing at edge %0d: got 0 required 1", edge_cnt);
            end
        end else if (o_tile_done) begin
            checks++;
            failures++;
            $display("FAIL tile_done unexpected at edge %0d: got 1 required 0", edge_cnt);
        end
        if (mq.size() > 0 && mq[0] == edge_cnt) begin
            checks++;
            void'(mq.pop_front());
            if (!o_mtrx_done) begin
                failures++;
                $display("FAIL mtrx_done missing at edge %0d: got 0 required 1", edge_cnt);
            end
        end else if (o_mtrx_done) begin
            checks++;
            failures++;
            $display("FAIL mtrx_done unexpected at edge %0d: got 1 required 0", edge_cnt);
        end
        if (dq.size() > 0 && dq[0].e == edge_cnt) begin
            ent = dq.pop_front();
            got = dut.A_BUF[3].ram_a.RD_PORT[0].rd_data_q;
            checks++;
            if ((got & ent.mask) != (ent.val & ent.mask)) begin
                failures++;
                $display("FAIL a3_rd_data at edge %0d: got %h required %h", edge_cnt,
                         got[15:0], ent.val[15:0]);
            end
        end
    end

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic start_run(input logic [1:0] mode, input int p, input int n_tiles,
                             input bit with_mtrx);
        i_start = 1'b1;
        i_mode  = mode;
        @(posedge clk);
        #1;
        e0      = edge_cnt;
        i_start = 1'b0;
        i_mode  = 2'($urandom_range(0, 3));
        for (int t = 0; t < n_tiles; t++) tq.push_back(e0 + p*t + p + 1);
        if (with_mtrx) mq.push_back(e0 + p*1024 + 2);
        $display("run mode=%0d start edge=%0d tiles_expected=%0d", mode, e0, n_tiles);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (mq.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (mq.size() != 0 || tq.size() != 0) begin
            failures++;
            $display("FAIL %s timeout: pending mtrx=%0d tiles=%0d required 0", name,
                     mq.size(), tq.size());
            mq.delete();
            tq.delete();
            dq.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, m0;
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_mode  = 2'd0;
        dut.A_BUF[3].ram_a.mem[0]  = mkword(8'h10, 8'h11);
        dut.A_BUF[3].ram_a.mem[1]  = mkword(8'h20, 8'h22);
        dut.A_BUF[3].ram_a.mem[2]  = mkword(8'h30, 8'h33);
        dut.A_BUF[3].ram_a.mem[3]  = mkword(8'h40, 8'hA5);
        dut.A_BUF[3].ram_a.mem[8]  = mkword(8'h80, 8'h88);
        dut.A_BUF[3].ram_a.mem[9]  = mkword(8'h9C, 8'h99);
        dut.A_BUF[3].ram_a.mem[10] = mkword(8'hA0, 8'hAA);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_tile_done", int'(o_tile_done), 0);
        check_eq("reset_mtrx_done", int'(o_mtrx_done), 0);
`ifdef MM_CTRL_PERF_EN
        check_eq("reset_busy", int'(busy), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Reserved mode: must be ignored.
        @(negedge clk);
        i_start = 1'b1;
        i_mode  = 2'd3;
        @(negedge clk);
        i_start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check_eq("mode3_tiles", tile_seen, 0);
        check_eq("mode3_mtrx", mtrx_seen, 0);
        $display("mode3 start ignored: tiles=%0d mtrx=%0d", tile_seen, mtrx_seen);

        // INT4 with address check and a spurious start mid-run.
        @(negedge clk);
        t0 = tile_seen; m0 = mtrx_seen;
        start_run(2'd1, 4, 1024, 1'b1);
        for (int cg = 0; cg < 32; cg++) begin
            int t = 64 + cg;
            if (cg == 0) dq.push_back('{e0 + 4*t + 1, mkword(8'h80, 8'h88), FULL});
            dq.push_back('{e0 + 4*t + 2, mkword(8'h9C, 8'h99), FULL});
        end
        repeat (50) @(negedge clk);
        i_start = 1'b1;
        i_mode  = 2'd0;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(4200, "int4");
        check_eq("int4_tiles", tile_seen - t0, 1024);
        check_eq("int4_mtrx", mtrx_seen - m0, 1);
`ifdef MM_CTRL_PERF_EN
        check_eq("int4_busy", int'(busy), 4096);
`endif

        // INT8, started on the cycle right after the done pulse.
        t0 = tile_seen; m0 = mtrx_seen;
        start_run(2'd0, 8, 1024, 1'b1);
        dq.push_back('{e0 + 3, mkword(8'h20, 8'h22), FULL});
        dq.push_back('{e0 + 4, mkword(8'h20, 8'h22), FULL});
        dq.push_back('{e0 + 5, mkword(8'h30, 8'h33), FULL});
        wait_done(8300, "int8");
        check_eq("int8_tiles", tile_seen - t0, 1024);
        check_eq("int8_mtrx", mtrx_seen - m0, 1);

        // INT4_VSQ: fifth cycle of each rg=0 tile returns vec 3's scale byte.
        @(negedge clk);
        t0 = tile_seen; m0 = mtrx_seen;
        start_run(2'd2, 5, 1024, 1'b1);
        dq.push_back('{e0 + 1, mkword(8'h10, 8'h11), SCALE});
        for (int t = 0; t < 32; t++) dq.push_back('{e0 + 5*t + 5, mkword(8'h00, 8'hA5), SCALE});
        wait_done(5300, "vsq");
        check_eq("vsq_tiles", tile_seen - t0, 1024);
        check_eq("vsq_mtrx", mtrx_seen - m0, 1);
`ifdef MM_CTRL_PERF_EN
        check_eq("vsq_busy", int'(busy), 5120);
`endif

        // Reset at E100 of an INT4 run: tiles 0..23 complete, nothing after.
        @(negedge clk);
        t0 = tile_seen; m0 = mtrx_seen;
        start_run(2'd1, 4, 24, 1'b0);
        for (int n = 0; n < 200 && edge_cnt < e0 + 100; n++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_tile_done", int'(o_tile_done), 0);
        check_eq("rst_mtrx_done", int'(o_mtrx_done), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check_eq("rst_tiles", tile_seen - t0, 24);
        check_eq("rst_mtrx", mtrx_seen - m0, 0);
        check_eq("rst_pending", tq.size(), 0);
`ifdef MM_CTRL_PERF_EN
        check_eq("rst_busy", int'(busy), 0);
`endif

        // Fresh run after reset completes normally.
        @(negedge clk);
        t0 = tile_seen; m0 = mtrx_seen;
        start_run(2'd1, 4, 1024, 1'b1);
        wait_done(4200, "post_rst");
        check_eq("post_rst_tiles", tile_seen - t0, 1024);
        check_eq("post_rst_mtrx", mtrx_seen - m0, 1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
